// File: rtl/regfile_wb_queue.sv
// Writeback queue that feeds the regfile write port one entry per cycle.
// It also forwards still-queued values to two decode lookup ports.
module regfile_wb_queue #(
   parameter int unsigned N     = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   in_wa,
   input  logic [N-1:0] in_wd,
   input  logic         wb_hold,
   output logic         we3,
   output logic [4:0]   wa3,
   output logic [N-1:0] wd3,
   input  logic [4:0]   q1_ra,
   output logic         q1_hit,
   output logic [N-1:0] q1_data,
   input  logic [4:0]   q2_ra,
   output logic         q2_hit,
   output logic [N-1:0] q2_data,
   output logic         empty,
   output logic         full
);

   localparam int unsigned AW  = 5;
   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] XZR = AW'(31);

   logic [AW-1:0] mem_wa [DEPTH];
   logic [N-1:0]  mem_wd [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   logic          push, pop;

   assign empty    = (count == CW'(0));
   assign full     = (count == CW'(DEPTH));
   assign in_ready = !full;
   assign push     = in_valid && in_ready && (in_wa != XZR);
   assign pop      = we3;

   // Idle drain drives XZR so the regfile bypass compare resolves to zero.
   assign we3 = !empty && !wb_hold;
   assign wa3 = we3 ? mem_wa[head] : XZR;
   assign wd3 = we3 ? mem_wd[head] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_wa[tail] <= in_wa;
         mem_wd[tail] <= in_wd;
      end
   end

   // Walk oldest to youngest so the last match (nearest tail) wins.
   always_comb begin
      logic [PW-1:0] idx;
      q1_hit  = 1'b0;
      q1_data = '0;
      q2_hit  = 1'b0;
      q2_data = '0;
      idx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count) begin
            if (q1_ra != XZR && mem_wa[idx] == q1_ra) begin
               q1_hit  = 1'b1;
               q1_data = mem_wd[idx];
            end
            if (q2_ra != XZR && mem_wa[idx] == q2_ra) begin
               q2_hit  = 1'b1;
               q2_data = mem_wd[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_regfile_wb_queue;

   localparam int unsigned N     = 64;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [4:0]   wa;
      logic [N-1:0] wd;
   } ent_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [4:0]   in_wa = '0;
   logic [N-1:0] in_wd = '0;
   logic         wb_hold = 1'b0;
   logic         we3;
   logic [4:0]   wa3;
   logic [N-1:0] wd3;
   logic [4:0]   q1_ra = 5'd31;
   logic         q1_hit;
   logic [N-1:0] q1_data;
   logic [4:0]   q2_ra = 5'd31;
   logic         q2_hit;
   logic [N-1:0] q2_data;
   logic         empty;
   logic         full;

   int   errors = 0;
   int   checks = 0;
   ent_t mq[$];

   regfile_wb_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_wa(in_wa), .in_wd(in_wd),
      .wb_hold(wb_hold), .we3(we3), .wa3(wa3), .wd3(wd3),
      .q1_ra(q1_ra), .q1_hit(q1_hit), .q1_data(q1_data),
      .q2_ra(q2_ra), .q2_hit(q2_hit), .q2_data(q2_data),
      .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // Reference: youngest queued write to ra, XZR never hits.
   function automatic logic [N:0] model_lookup(input logic [4:0] ra);
      logic [N:0] r;
      r = '0;
      if (ra != 5'd31)
         foreach (mq[i]) if (mq[i].wa == ra) r = {1'b1, mq[i].wd};
      return r;
   endfunction

   // One clock with the currently driven inputs; model follows the queue rules.
   task automatic tick();
      bit do_push, do_pop;
      do_push = in_valid && (mq.size() < DEPTH) && (in_wa != 5'd31);
      do_pop  = (mq.size() > 0) && !wb_hold;
      @(posedge clk);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{wa: in_wa, wd: in_wd});
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_wa = 5'd3; in_wd = 64'hDEAD;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b want 0", we3); end
      checks++; if (wa3 !== 5'd31) begin errors++; $display("FAIL reset_wa3 got %0d want 31", wa3); end
      checks++; if (wd3 !== '0) begin errors++; $display("FAIL reset_wd3 got %h want 0", wd3); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
      in_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
      checks++; if (empty !== 1'b1 || we3 !== 1'b0) begin errors++; $display("FAIL reset_noentry got empty=%b we3=%b want 1 0", empty, we3); end
      mq.delete();
   endtask

   task automatic test_single();
      wb_hold = 1'b0;
      in_valid = 1'b1; in_wa = 5'd5; in_wd = 64'h1234;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if ({we3, wa3, wd3} !== {1'b1, 5'd5, 64'h1234}) begin errors++; $display("FAIL single_drain got we3=%b wa3=%0d wd3=%h want 1 5 1234", we3, wa3, wd3); end
      tick();
      checks++; if ({empty, we3, wa3} !== {1'b1, 1'b0, 5'd31}) begin errors++; $display("FAIL single_after got empty=%b we3=%b wa3=%0d want 1 0 31", empty, we3, wa3); end
   endtask

   task automatic test_fill();
      wb_hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_wa = 5'(i); in_wd = N'(i * 'h11);
         tick();
      end
      in_wa = 5'd9; in_wd = 64'h55;
      #1;
      checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got full=%b ready=%b want 1 0", full, in_ready); end
      tick();
      checks++; if (full !== 1'b1 || we3 !== 1'b0) begin errors++; $display("FAIL fill_hold got full=%b we3=%b want 1 0", full, we3); end
      wb_hold = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({we3, wa3, wd3} !== {1'b1, 5'(i + 1), N'((i + 1) * 'h11)}) begin
            errors++; $display("FAIL fill_order%0d got we3=%b wa3=%0d wd3=%h want 1 %0d %h", i, we3, wa3, wd3, i + 1, (i + 1) * 'h11);
         end
         if (i == 0) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_pop got %b want 0", in_ready); end
         end
         if (i == 1) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_next got %b want 1", in_ready); end
         end
         tick();
         if (i == 1) in_valid = 1'b0;
      end
      #1;
      checks++; if ({we3, wa3, wd3} !== {1'b1, 5'd9, 64'h55}) begin errors++; $display("FAIL fill_fifth got we3=%b wa3=%0d wd3=%h want 1 9 55", we3, wa3, wd3); end
      tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained got empty=%b want 1", empty); end
   endtask

   task automatic test_xzr();
      in_valid = 1'b1; in_wa = 5'd31; in_wd = 64'hFFFF;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL xzr_ready got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (empty !== 1'b1 || we3 !== 1'b0) begin errors++; $display("FAIL xzr_discard got empty=%b we3=%b want 1 0", empty, we3); end
   endtask

   task automatic test_forward();
      wb_hold = 1'b1;
      in_valid = 1'b1; in_wa = 5'd7; in_wd = 64'hA; tick();
      in_wd = 64'hB; tick();
      in_valid = 1'b0;
      q1_ra = 5'd7; q2_ra = 5'd31;
      #1;
      checks++; if ({q1_hit, q1_data} !== {1'b1, 64'hB}) begin errors++; $display("FAIL fwd_young got hit=%b data=%h want 1 b", q1_hit, q1_data); end
      checks++; if ({q2_hit, q2_data} !== {1'b0, 64'h0}) begin errors++; $display("FAIL fwd_xzr got hit=%b data=%h want 0 0", q2_hit, q2_data); end
      wb_hold = 1'b0; tick(); wb_hold = 1'b1;
      #1;
      checks++; if ({q1_hit, q1_data} !== {1'b1, 64'hB}) begin errors++; $display("FAIL fwd_after_pop got hit=%b data=%h want 1 b", q1_hit, q1_data); end
      wb_hold = 1'b0; tick();
      checks++; if (q1_hit !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fwd_drained got hit=%b empty=%b want 0 1", q1_hit, empty); end
   endtask

   task automatic test_async_reset();
      wb_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_wa = 5'(10 + i); in_wd = N'(100 + i); tick();
      end
      in_valid = 1'b0; wb_hold = 1'b0; q1_ra = 5'd11;
      #1 reset_n = 1'b0;
      #1;
      checks++; if ({we3, empty, wa3, wd3} !== {1'b0, 1'b1, 5'd31, 64'h0}) begin errors++; $display("FAIL arst_outputs got we3=%b empty=%b wa3=%0d wd3=%h want 0 1 31 0", we3, empty, wa3, wd3); end
      checks++; if (q1_hit !== 1'b0 || q1_data !== '0) begin errors++; $display("FAIL arst_lookup got hit=%b data=%h want 0 0", q1_hit, q1_data); end
      mq.delete();
      @(posedge clk); @(negedge clk);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (we3 !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL arst_stale%0d got we3=%b empty=%b want 0 1", i, we3, empty); end
      end
   endtask

   task automatic test_random();
      logic [N:0] e1, e2;
      logic       ewe;
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_wa    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
         in_wd    = {$urandom, $urandom};
         wb_hold  = ($urandom_range(0, 9) < 4);
         q1_ra    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
         q2_ra    = 5'($urandom_range(0, 31));
         #1;
         e1  = model_lookup(q1_ra);
         e2  = model_lookup(q2_ra);
         ewe = (mq.size() > 0) && !wb_hold;
         checks++; if ({empty, full, in_ready} !== {mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH}) begin
            errors++; $display("FAIL rnd_flags c=%0d got e=%b f=%b r=%b size=%0d", c, empty, full, in_ready, mq.size());
         end
         checks++; if ({we3, wa3, wd3} !== (ewe ? {1'b1, mq[0].wa, mq[0].wd} : {1'b0, 5'd31, 64'h0})) begin
            errors++; $display("FAIL rnd_drain c=%0d got we3=%b wa3=%0d wd3=%h want we3=%b", c, we3, wa3, wd3, ewe);
         end
         checks++; if ({q1_hit, q1_data} !== e1) begin errors++; $display("FAIL rnd_q1 c=%0d got %b %h want %b %h", c, q1_hit, q1_data, e1[N], e1[N-1:0]); end
         checks++; if ({q2_hit, q2_data} !== e2) begin errors++; $display("FAIL rnd_q2 c=%0d got %b %h want %b %h", c, q2_hit, q2_data, e2[N], e2[N-1:0]); end
         tick();
      end
      in_valid = 1'b0; wb_hold = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_xzr();
      test_forward();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
